// File: rtl/door_pkg.sv
// Shared encodings for the room door controller: FSM states, exit directions and
// door_mask bit positions.
package door_pkg;

  typedef enum logic [2:0] {
    StLocked    = 3'd0,
    StUnlocking = 3'd1,
    StOpen      = 3'd2,
    StExiting   = 3'd3,
    StClosing   = 3'd4
  } door_state_e;

  typedef enum logic [1:0] {
    DirLeft   = 2'd0,
    DirRight  = 2'd1,
    DirTop    = 2'd2,
    DirBottom = 2'd3
  } door_dir_e;

  localparam int unsigned MaskLeft   = 0;
  localparam int unsigned MaskRight  = 1;
  localparam int unsigned MaskTop    = 2;
  localparam int unsigned MaskBottom = 3;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: tick pulses for one cycle every TICK_DIV clocks and is
// cleared only by reset.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic basys_clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == CntMax) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == CntMax);

endmodule

// File: rtl/door_controller.sv
// Room door sequencer: unlocks after room_clear, raises an exit request when the
// player reaches an open door, then closes and relocks.
module door_controller
  import door_pkg::*;
#(
  parameter int unsigned TICK_DIV          = 1_000_000,
  parameter int unsigned OPEN_DELAY_TICKS  = 50,
  parameter int unsigned CLOSE_DELAY_TICKS = 20,
  parameter int unsigned LEFT_EDGE_X       = 0,
  parameter int unsigned RIGHT_EDGE_X      = 95,
  parameter int unsigned TOP_EDGE_Y        = 0,
  parameter int unsigned BOT_EDGE_Y        = 63
) (
  input  logic       basys_clk,
  input  logic       reset,
  input  logic       room_clear,
  input  logic       lock,
  input  logic [3:0] door_mask,
  input  logic [6:0] player_x,
  input  logic [6:0] player_y,
  input  logic       exit_ack,
  output logic       left_door_open,
  output logic       right_door_open,
  output logic       top_door_open,
  output logic       bottom_door_open,
  output logic       exit_valid,
  output logic [1:0] exit_dir,
  output logic [2:0] state_out
);

  localparam int unsigned MaxDly = (OPEN_DELAY_TICKS > CLOSE_DELAY_TICKS) ?
                                   OPEN_DELAY_TICKS : CLOSE_DELAY_TICKS;
  localparam int unsigned DlyW   = (MaxDly < 1) ? 1 : $clog2(MaxDly + 1);

  door_state_e     r_state, w_state_nxt;
  logic [DlyW-1:0] r_delay, w_delay_nxt;
  logic [3:0]      r_mask, w_mask_nxt;
  door_dir_e       r_dir, w_dir_nxt, w_hit_dir;
  logic [3:0]      w_zone, w_hit, w_doors;
  logic            w_tick, w_expired;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .basys_clk (basys_clk),
    .reset     (reset),
    .tick      (w_tick)
  );

  // A zero load expires on the first cycle in the state.
  assign w_expired = (r_delay == '0) || (w_tick && (r_delay == DlyW'(1)));

  assign w_zone[MaskLeft]   = (player_x <= 7'(LEFT_EDGE_X));
  assign w_zone[MaskRight]  = (player_x >= 7'(RIGHT_EDGE_X));
  assign w_zone[MaskTop]    = (player_y <= 7'(TOP_EDGE_Y));
  assign w_zone[MaskBottom] = (player_y >= 7'(BOT_EDGE_Y));
  assign w_hit              = w_zone & r_mask;

  always_comb begin
    if (w_hit[MaskLeft])       w_hit_dir = DirLeft;
    else if (w_hit[MaskRight]) w_hit_dir = DirRight;
    else if (w_hit[MaskTop])   w_hit_dir = DirTop;
    else                       w_hit_dir = DirBottom;
  end

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      r_state <= StLocked;
      r_delay <= '0;
      r_mask  <= '0;
      r_dir   <= DirLeft;
    end else begin
      r_state <= w_state_nxt;
      r_delay <= w_delay_nxt;
      r_mask  <= w_mask_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_delay_nxt = r_delay;
    w_mask_nxt  = r_mask;
    w_dir_nxt   = r_dir;
    if (w_tick && (r_delay != '0)) w_delay_nxt = r_delay - 1'b1;
    unique case (r_state)
      StLocked: begin
        if (!lock && room_clear) begin
          w_mask_nxt  = door_mask;
          w_delay_nxt = DlyW'(OPEN_DELAY_TICKS);
          w_state_nxt = StUnlocking;
        end
      end
      StUnlocking: begin
        if (lock) begin
          w_mask_nxt  = '0;
          w_state_nxt = StLocked;
        end else if (w_expired) begin
          w_state_nxt = StOpen;
        end
      end
      StOpen: begin
        if (lock) begin
          w_mask_nxt  = '0;
          w_state_nxt = StLocked;
        end else if (|w_hit) begin
          w_dir_nxt   = w_hit_dir;
          w_state_nxt = StExiting;
        end
      end
      StExiting: begin
        if (exit_ack) begin
          w_delay_nxt = DlyW'(CLOSE_DELAY_TICKS);
          w_state_nxt = StClosing;
        end
      end
      StClosing: begin
        if (w_expired) begin
          w_mask_nxt  = '0;
          w_state_nxt = StLocked;
        end
      end
      default: w_state_nxt = StLocked;
    endcase
  end

  always_comb begin
    w_doors    = '0;
    exit_valid = 1'b0;
    exit_dir   = 2'd0;
    if ((r_state == StOpen) || (r_state == StExiting)) w_doors = r_mask;
    if (r_state == StExiting) begin
      exit_valid = 1'b1;
      exit_dir   = r_dir;
    end
  end

  assign left_door_open   = w_doors[MaskLeft];
  assign right_door_open  = w_doors[MaskRight];
  assign top_door_open    = w_doors[MaskTop];
  assign bottom_door_open = w_doors[MaskBottom];
  assign state_out        = r_state;

endmodule

// File: tb/tb_door_controller.sv
// Directed bench for door_controller with short timing (TICK_DIV=4, open 3 ticks,
// close 2 ticks); expected values are hand-derived constants.
module tb_door_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       room_clear = 1'b0;
  logic       lock = 1'b0;
  logic [3:0] door_mask = 4'b0000;
  logic [6:0] player_x = 7'd48;
  logic [6:0] player_y = 7'd32;
  logic       exit_ack = 1'b0;
  logic       left_o, right_o, top_o, bottom_o, exit_valid;
  logic [1:0] exit_dir;
  logic [2:0] state_out;
  logic [3:0] doors;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign doors = {bottom_o, top_o, right_o, left_o};

  door_controller #(
    .TICK_DIV          (4),
    .OPEN_DELAY_TICKS  (3),
    .CLOSE_DELAY_TICKS (2),
    .LEFT_EDGE_X       (0),
    .RIGHT_EDGE_X      (95),
    .TOP_EDGE_Y        (0),
    .BOT_EDGE_Y        (63)
  ) dut (
    .basys_clk        (clk),
    .reset            (reset),
    .room_clear       (room_clear),
    .lock             (lock),
    .door_mask        (door_mask),
    .player_x         (player_x),
    .player_y         (player_y),
    .exit_ack         (exit_ack),
    .left_door_open   (left_o),
    .right_door_open  (right_o),
    .top_door_open    (top_o),
    .bottom_door_open (bottom_o),
    .exit_valid       (exit_valid),
    .exit_dir         (exit_dir),
    .state_out        (state_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; room_clear = 1'b0; lock = 1'b0; exit_ack = 1'b0;
    player_x = 7'd48; player_y = 7'd32;
    step();
    reset = 1'b0;
  endtask

  // Waits until state_out == s; k = cycles waited, or -1 on timeout.
  task automatic wait_state(input logic [2:0] s, input int maxc, output int k);
    k = -1;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (state_out == s) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic open_room(input logic [3:0] m);
    int k;
    door_mask = m; room_clear = 1'b1;
    step();
    room_clear = 1'b0;
    wait_state(3'd2, 20, k);
    n_tests++;
    if (k < 0) begin
      n_fail++;
      $display("FAIL open_room: state %0d, required 2 within 20 cycles", state_out);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({state_out, doors, exit_valid, exit_dir} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: state %0d doors %b valid %b dir %0d, required all 0",
               state_out, doors, exit_valid, exit_dir);
    end
  endtask

  task automatic test_open_latency();
    int k;
    do_reset();
    door_mask = 4'b1111; room_clear = 1'b1;
    step();
    room_clear = 1'b0;
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      n_tests++;
      if (!((doors === 4'b0000) || (doors === 4'b1111)) || exit_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL open_together: doors %b valid %b, required 0000/1111 and 0", doors,
                 exit_valid);
      end
      if (doors === 4'b1111) begin
        k = i;
        break;
      end
      step();
    end
    n_tests++;
    if (k < 9 || k > 12) begin
      n_fail++;
      $display("FAIL open_latency: %0d cycles, required 9..12", k);
    end
    n_tests++;
    if (state_out !== 3'd2) begin
      n_fail++;
      $display("FAIL open_state: %0d, required 2", state_out);
    end
  endtask

  task automatic test_masked_exit();
    do_reset();
    open_room(4'b0101);
    n_tests++;
    if (doors !== 4'b0101) begin
      n_fail++;
      $display("FAIL masked_doors: %b, required 0101", doors);
    end
    player_x = 7'd95; door_mask = 4'b1111;
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if (exit_valid !== 1'b0 || state_out !== 3'd2 || doors !== 4'b0101) begin
      n_fail++;
      $display("FAIL masked_right: valid %b state %0d doors %b, required 0 2 0101",
               exit_valid, state_out, doors);
    end
    player_x = 7'd0;
    step();
    n_tests++;
    if (exit_valid !== 1'b1 || exit_dir !== 2'd0 || state_out !== 3'd3) begin
      n_fail++;
      $display("FAIL left_exit: valid %b dir %0d state %0d, required 1 0 3", exit_valid,
               exit_dir, state_out);
    end
  endtask

  task automatic test_exit_handshake();
    int k;
    player_x = 7'd48;
    for (int i = 0; i < 20; i++) begin
      step();
      n_tests++;
      if (exit_valid !== 1'b1 || exit_dir !== 2'd0 || doors !== 4'b0101) begin
        n_fail++;
        $display("FAIL exit_hold: valid %b dir %0d doors %b, required 1 0 0101", exit_valid,
                 exit_dir, doors);
      end
    end
    exit_ack = 1'b1;
    step();
    exit_ack = 1'b0;
    n_tests++;
    if (exit_valid !== 1'b0 || doors !== 4'b0000 || state_out !== 3'd4) begin
      n_fail++;
      $display("FAIL exit_ack: valid %b doors %b state %0d, required 0 0000 4", exit_valid,
               doors, state_out);
    end
    wait_state(3'd0, 20, k);
    n_tests++;
    if (k < 4 || k > 7) begin
      n_fail++;
      $display("FAIL close_latency: %0d cycles after ack, required 5..8", k + 1);
    end
  endtask

  task automatic test_priority();
    do_reset();
    open_room(4'b1111);
    player_x = 7'd0; player_y = 7'd0;
    step();
    n_tests++;
    if (exit_valid !== 1'b1 || exit_dir !== 2'd0) begin
      n_fail++;
      $display("FAIL prio_left_top: valid %b dir %0d, required 1 0", exit_valid, exit_dir);
    end
    do_reset();
    open_room(4'b1111);
    player_x = 7'd95; player_y = 7'd63;
    step();
    n_tests++;
    if (exit_valid !== 1'b1 || exit_dir !== 2'd1) begin
      n_fail++;
      $display("FAIL prio_right_bot: valid %b dir %0d, required 1 1", exit_valid, exit_dir);
    end
  endtask

  task automatic test_lock();
    int k;
    do_reset();
    door_mask = 4'b1111; room_clear = 1'b1;
    step();
    room_clear = 1'b0;
    step(); step();
    n_tests++;
    if (state_out !== 3'd1) begin
      n_fail++;
      $display("FAIL unlocking_state: %0d, required 1", state_out);
    end
    lock = 1'b1;
    step();
    lock = 1'b0;
    n_tests++;
    if (state_out !== 3'd0) begin
      n_fail++;
      $display("FAIL lock_unlocking: state %0d, required 0", state_out);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      n_tests++;
      if (doors !== 4'b0000 || state_out !== 3'd0) begin
        n_fail++;
        $display("FAIL lock_stays: doors %b state %0d, required 0000 0", doors, state_out);
      end
    end
    open_room(4'b1111);
    player_x = 7'd0;
    step();
    player_x = 7'd48; lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (state_out !== 3'd3 || exit_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL lock_exiting: state %0d valid %b, required 3 1", state_out, exit_valid);
      end
    end
    exit_ack = 1'b1;
    step();
    exit_ack = 1'b0;
    n_tests++;
    if (state_out !== 3'd4) begin
      n_fail++;
      $display("FAIL lock_ack: state %0d, required 4", state_out);
    end
    wait_state(3'd0, 20, k);
    lock = 1'b0;
    n_tests++;
    if (k < 4 || k > 7) begin
      n_fail++;
      $display("FAIL lock_closing: %0d cycles, required 4..7", k);
    end
  endtask

  task automatic test_closing();
    int k;
    do_reset();
    open_room(4'b1111);
    player_x = 7'd0;
    step();
    player_x = 7'd48; exit_ack = 1'b1;
    step();
    exit_ack = 1'b0;
    step();
    room_clear = 1'b1;
    step();
    room_clear = 1'b0;
    n_tests++;
    if (state_out !== 3'd4) begin
      n_fail++;
      $display("FAIL clear_in_closing: state %0d, required 4", state_out);
    end
    wait_state(3'd0, 20, k);
    n_tests++;
    if (k < 0) begin
      n_fail++;
      $display("FAIL closing_expire: state %0d, required 0", state_out);
    end
    for (int i = 0; i < 15; i++) step();
    n_tests++;
    if (state_out !== 3'd0 || doors !== 4'b0000) begin
      n_fail++;
      $display("FAIL clear_dropped: state %0d doors %b, required 0 0000", state_out, doors);
    end
    open_room(4'b1111);
    player_x = 7'd0;
    step();
    player_x = 7'd48; exit_ack = 1'b1;
    step();
    exit_ack = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++;
    if ({state_out, doors, exit_valid, exit_dir} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_closing: state %0d doors %b valid %b dir %0d, required all 0",
               state_out, doors, exit_valid, exit_dir);
    end
  endtask

  initial begin
    test_reset();
    test_open_latency();
    test_masked_exit();
    test_exit_handshake();
    test_priority();
    test_lock();
    test_closing();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
